// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared constants for the pipeline stall/flush sequencer
package pipe_ctrl_pkg;
   typedef enum logic [1:0] {
      RUN  = 2'b00,
      WAIT = 2'b01,
      ERR  = 2'b10
   } state_t;
   localparam logic [31:0] NOP = 32'h0000_0000;
   localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] q
);
   // count up on inc, hold once saturated
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= '0;
      else if (inc && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: merges load-use, branch and dmem-wait hazards into stage enables
module pipeline_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       RegS,
   input  logic [4:0]       RegT,
   input  logic             id_ex_MemRead,
   input  logic [4:0]       id_ex_RegRt,
   input  logic             branch_taken,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             PCWrite,
   output logic             if_id_Write,
   output logic             if_id_Flush,
   output logic             id_ex_Bubble,
   output logic             ex_mem_Write,
   output logic             mem_wb_Bubble,
   output logic             mem_err,
   output logic [CNT_W-1:0] lu_stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] mem_wait_cnt
);
   localparam int WW = MEM_TIMEOUT > 2 ? $clog2(MEM_TIMEOUT) : 1;
   state_t state, state_nxt;
   logic [WW-1:0] wait_ctr, wait_nxt;
   logic load_use, mem_stall, freeze, lu_act, br_act;
   // state and wait counter registers; reset returns to RUN mid-access
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state    <= RUN;
         wait_ctr <= '0;
      end else begin
         state    <= state_nxt;
         wait_ctr <= wait_nxt;
      end
   // hazard priority, next state and stage enables; everything off in reset
   always_comb begin
      load_use  = id_ex_MemRead && id_ex_RegRt != REG_ZERO &&
                  (RegS == id_ex_RegRt || RegT == id_ex_RegRt);
      mem_stall = dmem_req && !dmem_ready && state != ERR;
      freeze    = mem_stall || state == ERR;
      lu_act    = !freeze && load_use;
      br_act    = !freeze && !load_use && branch_taken;
      state_nxt = state;
      wait_nxt  = wait_ctr;
      if (state == RUN && mem_stall) begin
         state_nxt = WAIT;
         wait_nxt  = '0;
      end else if (state == WAIT) begin
         if (dmem_ready) state_nxt = RUN;
         else if (wait_ctr == WW'(MEM_TIMEOUT - 1)) state_nxt = ERR;
         else wait_nxt = wait_ctr + 1'b1;
      end
      PCWrite       = rst_n && !freeze && !lu_act;
      if_id_Write   = rst_n && !freeze && !lu_act;
      if_id_Flush   = rst_n && br_act;
      id_ex_Bubble  = rst_n && lu_act;
      ex_mem_Write  = rst_n && !freeze;
      mem_wb_Bubble = rst_n && freeze;
      mem_err       = rst_n && state == ERR;
   end
   sat_counter #(.W(CNT_W)) u_lu (.clk(clk), .rst_n(rst_n), .inc(lu_act), .q(lu_stall_cnt));
   sat_counter #(.W(CNT_W)) u_fl (.clk(clk), .rst_n(rst_n), .inc(br_act), .q(flush_cnt));
   sat_counter #(.W(CNT_W)) u_mw (.clk(clk), .rst_n(rst_n), .inc(mem_stall), .q(mem_wait_cnt));
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed plus random checks of pipeline_ctrl against a behavioural model
module tb_pipeline_ctrl;
   localparam int T = 4;
   localparam int W = 2;
   localparam int MAXC = (1 << W) - 1;
   logic clk = 0, rst_n = 0;
   logic [4:0] RegS = 0, RegT = 0, id_ex_RegRt = 0;
   logic id_ex_MemRead = 0, branch_taken = 0, dmem_req = 0, dmem_ready = 0;
   logic PCWrite, if_id_Write, if_id_Flush, id_ex_Bubble, ex_mem_Write, mem_wb_Bubble, mem_err;
   logic [W-1:0] lu_stall_cnt, flush_cnt, mem_wait_cnt;
   int total = 0, passed = 0, fails = 0;
   bit m_err, m_waiting;
   int m_wc, m_lu, m_fl, m_mw;

   always #5 clk = ~clk;

   pipeline_ctrl #(.MEM_TIMEOUT(T), .CNT_W(W)) dut (
      .clk(clk), .rst_n(rst_n), .RegS(RegS), .RegT(RegT),
      .id_ex_MemRead(id_ex_MemRead), .id_ex_RegRt(id_ex_RegRt),
      .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .PCWrite(PCWrite), .if_id_Write(if_id_Write), .if_id_Flush(if_id_Flush),
      .id_ex_Bubble(id_ex_Bubble), .ex_mem_Write(ex_mem_Write), .mem_wb_Bubble(mem_wb_Bubble),
      .mem_err(mem_err), .lu_stall_cnt(lu_stall_cnt), .flush_cnt(flush_cnt),
      .mem_wait_cnt(mem_wait_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      total++;
      assert (o === e) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic idle();
      {id_ex_MemRead, branch_taken, dmem_req, dmem_ready} = '0;
      RegS = 0; RegT = 0; id_ex_RegRt = 0;
   endtask

   task automatic do_reset(input string tag);
      rst_n = 0;
      #1;
      chk({tag, ".PCWrite"}, PCWrite, 0);
      chk({tag, ".if_id_Write"}, if_id_Write, 0);
      chk({tag, ".if_id_Flush"}, if_id_Flush, 0);
      chk({tag, ".id_ex_Bubble"}, id_ex_Bubble, 0);
      chk({tag, ".ex_mem_Write"}, ex_mem_Write, 0);
      chk({tag, ".mem_wb_Bubble"}, mem_wb_Bubble, 0);
      chk({tag, ".mem_err"}, mem_err, 0);
      chk({tag, ".lu_cnt"}, lu_stall_cnt, 0);
      chk({tag, ".fl_cnt"}, flush_cnt, 0);
      chk({tag, ".mw_cnt"}, mem_wait_cnt, 0);
      idle();
      @(posedge clk);
      #1 rst_n = 1;
      m_err = 0; m_waiting = 0; m_wc = 0; m_lu = 0; m_fl = 0; m_mw = 0;
   endtask

   task automatic cycle(input string tag);
      bit stall, frz, lu, br;
      @(negedge clk);
      stall = dmem_req && !dmem_ready && !m_err;
      frz   = stall || m_err;
      lu    = !frz && id_ex_MemRead && id_ex_RegRt != 0 &&
              (RegS == id_ex_RegRt || RegT == id_ex_RegRt);
      br    = !frz && !lu && branch_taken;
      chk({tag, ".PCWrite"}, PCWrite, !frz && !lu);
      chk({tag, ".if_id_Write"}, if_id_Write, !frz && !lu);
      chk({tag, ".if_id_Flush"}, if_id_Flush, br);
      chk({tag, ".id_ex_Bubble"}, id_ex_Bubble, lu);
      chk({tag, ".ex_mem_Write"}, ex_mem_Write, !frz);
      chk({tag, ".mem_wb_Bubble"}, mem_wb_Bubble, frz);
      chk({tag, ".mem_err"}, mem_err, m_err);
      chk({tag, ".lu_cnt"}, lu_stall_cnt, m_lu);
      chk({tag, ".fl_cnt"}, flush_cnt, m_fl);
      chk({tag, ".mw_cnt"}, mem_wait_cnt, m_mw);
      @(posedge clk);
      if (lu && m_lu < MAXC) m_lu++;
      if (br && m_fl < MAXC) m_fl++;
      if (stall && m_mw < MAXC) m_mw++;
      if (!m_err) begin
         if (m_waiting) begin
            if (dmem_ready) m_waiting = 0;
            else begin
               m_wc++;
               if (m_wc == T) m_err = 1;
            end
         end else if (stall) begin
            m_waiting = 1;
            m_wc = 0;
         end
      end
      #1;
   endtask

   initial begin
      #12;
      do_reset("reset");
      id_ex_MemRead = 1; id_ex_RegRt = 8; RegS = 8;
      cycle("lu");
      id_ex_MemRead = 0;
      cycle("lu_after");
      chk("lu_cnt_one", lu_stall_cnt, 1);
      id_ex_MemRead = 1; id_ex_RegRt = 0; RegS = 0;
      cycle("lu_zero");
      idle(); branch_taken = 1;
      cycle("br");
      branch_taken = 0;
      cycle("br_after");
      chk("fl_cnt_one", flush_cnt, 1);
      branch_taken = 1; id_ex_MemRead = 1; id_ex_RegRt = 9; RegT = 9;
      cycle("br_lu");
      idle();
      cycle("br_lu_after");
      chk("fl_cnt_hold", flush_cnt, 1);
      chk("lu_cnt_two", lu_stall_cnt, 2);
      dmem_req = 1; dmem_ready = 0; id_ex_MemRead = 1; id_ex_RegRt = 8; RegS = 8;
      repeat (3) cycle("mw");
      dmem_ready = 1;
      cycle("mw_release");
      idle();
      cycle("mw_after");
      chk("mw_cnt_three", mem_wait_cnt, 3);
      id_ex_MemRead = 1; id_ex_RegRt = 5; RegT = 5;
      repeat (2) begin
         cycle("sat_lu");
         id_ex_MemRead = 0;
         cycle("sat_gap");
         id_ex_MemRead = 1;
      end
      idle();
      chk("lu_cnt_sat", lu_stall_cnt, 3);
      dmem_req = 1; dmem_ready = 0;
      repeat (T) cycle("bnd_wait");
      dmem_ready = 1;
      cycle("bnd_ready");
      idle();
      cycle("bnd_after");
      chk("bnd_no_err", mem_err, 0);
      dmem_req = 1; dmem_ready = 0;
      repeat (T + 1) cycle("to_wait");
      idle(); branch_taken = 1;
      repeat (3) cycle("err_hold");
      chk("err_flag", mem_err, 1);
      chk("err_frozen", PCWrite, 0);
      do_reset("err_reset");
      cycle("post_err");
      dmem_req = 1; dmem_ready = 0;
      repeat (2) cycle("ar_wait");
      #3;
      do_reset("async_reset");
      cycle("post_async");
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 49) == 0) do_reset("rnd_reset");
         id_ex_MemRead = $urandom_range(0, 2) == 0;
         id_ex_RegRt   = 5'($urandom_range(0, 3));
         RegS          = 5'($urandom_range(0, 3));
         RegT          = 5'($urandom_range(0, 3));
         branch_taken  = $urandom_range(0, 3) == 0;
         dmem_req      = $urandom_range(0, 1) == 1;
         dmem_ready    = $urandom_range(0, 2) == 0;
         cycle("rnd");
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
